// File: rtl/mem_filter_sched_if.sv
// Handshake bundle between the NoC write path, the filter scheduler and the packetizer.
interface mem_filter_sched_if #(
  parameter int WIDTH_data     = 8,
  parameter int WIDTH_addr     = 12,
  parameter int WIDTH_dest     = 4,
  parameter int WIDTH_datatype = 2
);
  localparam int PW = WIDTH_dest + WIDTH_datatype + WIDTH_addr + WIDTH_data;

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH_addr-1:0] in_addr;
  logic [WIDTH_data-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [PW-1:0]         out_packet;
  logic                  done;
  logic                  err_addr;

  modport master (
    output in_valid, in_addr, in_data, out_ready,
    input  in_ready, out_valid, out_packet, done, err_addr
  );

  modport slave (
    input  in_valid, in_addr, in_data, out_ready,
    output in_ready, out_valid, out_packet, done, err_addr
  );
endinterface

// File: rtl/mem_filter_sched.sv
// Filter-weight memory: collects DEPTH_F x DEPTH_F weights, then broadcasts them
// row by row as {dest, datatype, addr, data} packets.
module mem_filter_sched #(
  parameter int WIDTH_data     = 8,
  parameter int WIDTH_addr     = 12,
  parameter int WIDTH_dest     = 4,
  parameter int WIDTH_datatype = 2,
  parameter int DEPTH_F        = 5,
  parameter int DEST_BASE      = 0,
  parameter int TYPE_FILTER    = 0
) (
  input logic clk,
  input logic rst,
  mem_filter_sched_if.slave bus
);
  localparam int N    = DEPTH_F * DEPTH_F;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int CNTW = $clog2(N + 1);
  localparam int RW   = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1;
  localparam int PW   = WIDTH_dest + WIDTH_datatype + WIDTH_addr + WIDTH_data;

  typedef enum logic [1:0] {LOAD, SEND, DONE} state_t;

  state_t                state;
  logic [WIDTH_data-1:0] mem [N];
  logic [N-1:0]          loaded;
  logic [CNTW-1:0]       count;
  logic [IW-1:0]         idx;
  logic [RW-1:0]         row;
  logic [RW-1:0]         col;
  logic                  in_ready_r;
  logic                  vld_p1;
  logic [PW-1:0]         pkt_p1;
  logic                  done_r;
  logic                  err_r;

  logic                  addr_ok;
  logic [IW-1:0]         waddr;
  logic                  wr_en;
  logic [IW-1:0]         nidx;
  logic [RW-1:0]         nrow;
  logic [RW-1:0]         ncol;

  function automatic logic [PW-1:0] make_pkt(input logic [RW-1:0] r,
                                             input logic [IW-1:0] i,
                                             input logic [WIDTH_data-1:0] d);
    logic [WIDTH_dest-1:0] dst;
    dst = WIDTH_dest'(DEST_BASE) + WIDTH_dest'(r);
    return {dst, WIDTH_datatype'(TYPE_FILTER), WIDTH_addr'(i), d};
  endfunction

  assign addr_ok = (32'(bus.in_addr) < 32'(N));
  assign waddr   = bus.in_addr[IW-1:0];
  assign wr_en   = (state == LOAD) && in_ready_r && bus.in_valid && addr_ok;

  // Row/column stepping replaces a divide by DEPTH_F on the read index.
  always_comb begin
    nidx = idx + IW'(1);
    nrow = row;
    ncol = col + RW'(1);
    if (col == RW'(DEPTH_F - 1)) begin
      ncol = '0;
      nrow = row + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      loaded     <= '0;
      count      <= '0;
      idx        <= '0;
      row        <= '0;
      col        <= '0;
      in_ready_r <= 1'b0;
      vld_p1     <= 1'b0;
      pkt_p1     <= '0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          in_ready_r <= 1'b1;
          if (in_ready_r && bus.in_valid) begin
            if (!addr_ok) begin
              err_r <= 1'b1;
            end else if (!loaded[waddr]) begin
              loaded[waddr] <= 1'b1;
              count         <= count + CNTW'(1);
              if (count == CNTW'(N - 1)) begin
                state      <= SEND;
                in_ready_r <= 1'b0;
              end
            end
          end
        end
        // p1: packet register, reloaded from the array on each acceptance
        SEND: begin
          if (!vld_p1) begin
            vld_p1 <= 1'b1;
            pkt_p1 <= make_pkt(row, idx, mem[idx]);
          end else if (bus.out_ready) begin
            if (idx == IW'(N - 1)) begin
              vld_p1 <= 1'b0;
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              idx    <= nidx;
              row    <= nrow;
              col    <= ncol;
              pkt_p1 <= make_pkt(nrow, nidx, mem[nidx]);
            end
          end
        end
        DONE: begin
          done_r     <= 1'b0;
          loaded     <= '0;
          count      <= '0;
          idx        <= '0;
          row        <= '0;
          col        <= '0;
          in_ready_r <= 1'b1;
          state      <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = vld_p1;
  assign bus.out_packet = pkt_p1;
  assign bus.done       = done_r;
  assign bus.err_addr   = err_r;
endmodule

// File: tb/tb_mem_filter_sched.sv
// Bench for mem_filter_sched: vector table plus randomized frames against an array model.
module tb_mem_filter_sched;
  localparam int WD = 8, WA = 12, WDS = 4, WT = 2, DF = 5;
  localparam int N  = DF * DF;
  localparam int PW = WDS + WT + WA + WD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_filter_sched_if #(.WIDTH_data(WD), .WIDTH_addr(WA), .WIDTH_dest(WDS),
                        .WIDTH_datatype(WT)) bus ();

  mem_filter_sched #(.WIDTH_data(WD), .WIDTH_addr(WA), .WIDTH_dest(WDS),
                     .WIDTH_datatype(WT), .DEPTH_F(DF), .DEST_BASE(0),
                     .TYPE_FILTER(0)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [WA-1:0] addr;
    logic [WD-1:0] data;
    bit            exp_err;
    bit            exp_ready;
  } vec_t;

  int tests = 0, failed = 0;
  logic [WD-1:0] ref_mem [N];
  bit            ref_loaded [N];
  bit            ref_err = 1'b0;
  logic [PW-1:0] got_pkt [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(output bit xin, output bit xout);
    xin  = bus.in_valid && bus.in_ready;
    xout = bus.out_valid && bus.out_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a, b;
    for (int i = 0; i < n; i++) step(a, b);
  endtask

  function automatic logic [PW-1:0] exp_pkt(input int k);
    logic [WDS-1:0] dst;
    logic [WA-1:0]  ad;
    dst = WDS'(k / DF);
    ad  = WA'(k);
    return {dst, 2'b00, ad, ref_mem[k]};
  endfunction

  function automatic bit all_loaded();
    for (int i = 0; i < N; i++) if (!ref_loaded[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) ref_loaded[i] = 1'b0;
  endtask

  task automatic send_word(input logic [WA-1:0] a, input logic [WD-1:0] d, output bit full);
    bit xi, xo;
    int w = 0;
    full = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    do begin
      step(xi, xo);
      w++;
    end while (!xi && w < 50);
    bus.in_valid = 1'b0;
    if (!xi) begin
      tests++; failed++;
      $display("FAIL accept_timeout: addr %0d never accepted (in_ready=%b)", a, bus.in_ready);
    end else if (a < WA'(N)) begin
      ref_mem[a]    = d;
      ref_loaded[a] = 1'b1;
      full = all_loaded();
    end else begin
      ref_err = 1'b1;
    end
  endtask

  // Called right after the final write is accepted.
  task automatic recv_frame(input int mode, input int stop_at);
    bit xi, xo, stalled;
    int k, cyc;
    logic [PW-1:0] held;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    k = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (k < stop_at && cyc < 400) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = pat[cyc % 6];
        default: bus.out_ready = ($urandom_range(0, 9) < 6);
      endcase
      if (bus.out_valid) begin
        if (stalled) chk("stall_hold", bus.out_packet, held);
        if (bus.out_ready) begin
          chk($sformatf("pkt%0d", k), bus.out_packet, exp_pkt(k));
          got_pkt[k] = bus.out_packet;
          k++;
          stalled = 1'b0;
        end else begin
          held    = bus.out_packet;
          stalled = 1'b1;
        end
      end
      step(xi, xo);
      cyc++;
    end
    bus.out_ready = 1'b0;
    if (k < stop_at) begin
      tests++; failed++;
      $display("FAIL recv_timeout: got %0d packets, required %0d", k, stop_at);
    end else if (stop_at == N) begin
      if (mode == 0) chk("burst_cycles", 64'(cyc), 64'(N + 1));
      chk("done_pulse", bus.done, 1'b1);
      chk("valid_after_last", bus.out_valid, 1'b0);
      chk("err_sticky", bus.err_addr, ref_err);
      step(xi, xo);
      chk("done_once", bus.done, 1'b0);
      chk("ready_after_done", bus.in_ready, 1'b1);
      model_clear();
    end
  endtask

  task automatic load_seq(input bit descending);
    bit full;
    for (int i = 0; i < N; i++) begin
      int a;
      a = descending ? (N - 1 - i) : i;
      send_word(WA'(a), WD'(a + 1), full);
    end
    chk("full_flag", full, 1'b1);
    chk("ready_drop", bus.in_ready, 1'b0);
  endtask

  task automatic random_frame();
    bit full;
    full = 1'b0;
    while (!full) begin
      int r, a;
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom_range(N, 4095);
      else if (r < 6) a = $urandom_range(0, N - 1);
      else begin
        a = 0;
        for (int j = N - 1; j >= 0; j--) if (!ref_loaded[j]) a = j;
      end
      send_word(WA'(a), WD'($urandom), full);
      chk("rand_err", bus.err_addr, ref_err);
      if (!full) idle($urandom_range(0, 2));
    end
    chk("rand_ready_drop", bus.in_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    bit full;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin ref_mem[i] = '0; ref_loaded[i] = 1'b0; end

    vecs.push_back('{12'd7, 8'h11, 1'b0, 1'b1});
    vecs.push_back('{12'd7, 8'h22, 1'b0, 1'b1});
    for (int a = 0; a < N; a++) begin
      if (a == 11) vecs.push_back('{12'd30, 8'h55, 1'b1, 1'b1});
      if (a != 7) vecs.push_back('{WA'(a), WD'(a ^ 8'h5A), a > 10, a != N - 1});
    end

    // Reset state
    idle(2);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_packet", bus.out_packet, '0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err_addr, 1'b0);
    rst = 1'b0;
    idle(1);
    chk("post_rst_ready", bus.in_ready, 1'b1);

    // Ascending then descending load, full-rate drain
    load_seq(1'b0);
    recv_frame(0, N);
    load_seq(1'b1);
    recv_frame(0, N);

    // Vector table: duplicate overwrite and out-of-range address
    foreach (vecs[i]) begin
      send_word(vecs[i].addr, vecs[i].data, full);
      chk($sformatf("vec%0d_err", i), bus.err_addr, vecs[i].exp_err);
      chk($sformatf("vec%0d_ready", i), bus.in_ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d_full", i), full, !vecs[i].exp_ready);
    end
    recv_frame(1, N);
    chk("dup_addr", got_pkt[7][WD +: WA], 64'd7);
    chk("dup_data", got_pkt[7][WD-1:0], 64'h22);

    // Reset while packet 12 is pending
    send_word(12'd100, 8'h01, full);
    for (int i = 0; i < N; i++) send_word(WA'(i), WD'($urandom), full);
    recv_frame(2, 12);
    chk("pending12_valid", bus.out_valid, 1'b1);
    chk("pending12_addr", bus.out_packet[WD +: WA], 64'd12);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    ref_err = 1'b0;
    model_clear();
    chk("abort_valid", bus.out_valid, 1'b0);
    chk("abort_err", bus.err_addr, 1'b0);
    chk("abort_ready_rst", bus.in_ready, 1'b0);
    idle(1);
    chk("abort_ready", bus.in_ready, 1'b1);
    chk("abort_valid2", bus.out_valid, 1'b0);
    load_seq(1'b0);
    recv_frame(0, N);

    // Randomized frames
    for (int f = 0; f < 4; f++) begin
      random_frame();
      recv_frame(2, N);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/mem_filter_sched.md
Name: mem_filter_sched

Overview:
- Synchronous controller for the filter-weight memory: loads the DEPTH_F×DEPTH_F filter weights from the NoC side into a local array.
- Once every entry has been written, broadcasts the weights row by row as packets to the PE destinations.
- Sits between the NoC receive path and the packetizer/router interface; sequences both the write phase and the read/broadcast phase.

Parameters:
- WIDTH_data, 8, weight width
- WIDTH_addr, 12, address field width
- WIDTH_dest, 4, destination field width
- WIDTH_datatype, 2, datatype field width
- DEPTH_F, 5, filter dimension; memory holds DEPTH_F*DEPTH_F entries
- DEST_BASE, 0, dest of PE for row 0; row r goes to DEST_BASE+r
- TYPE_FILTER, 0, datatype code stamped on filter packets

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  write word valid
- in_ready  out  1  block accepts write word
- in_addr  in  WIDTH_addr  filter memory index
- in_data  in  WIDTH_data  weight value
- out_valid  out  1  packet valid
- out_ready  in  1  downstream accepts packet
- out_packet  out  WIDTH_dest+WIDTH_datatype+WIDTH_addr+WIDTH_data  {dest, datatype, addr, data}, MSB first
- done  out  1  one-cycle pulse after last packet accepted
- err_addr  out  1  sticky: an out-of-range address was received

Behaviour:
- Reset (rst=1 at posedge):
  - state=LOAD; loaded bitmap and load count cleared.
  - in_ready=0 during the reset cycle, 1 from the first cycle after.
  - out_valid=0, out_packet=0, done=0, err_addr=0.
  - Memory contents are don't-care.
  - Reset mid-broadcast aborts immediately; no further packets are issued.
- Transfer rule: a transfer occurs on a posedge with valid&ready, on either interface.
- LOAD state:
  - in_ready=1, out_valid=0.
  - Accepted word with in_addr < DEPTH_F*DEPTH_F: written to mem[in_addr].
    - Bitmap bit not yet set: set it and increment count.
    - Bitmap bit already set (duplicate): overwrite data only; count unchanged.
  - Accepted word with in_addr >= DEPTH_F*DEPTH_F: dropped, err_addr set (sticky until rst), count unchanged.
  - When an accept makes count reach DEPTH_F*DEPTH_F, next state is SEND. in_ready drops the following cycle.
- SEND state:
  - in_ready=0.
  - Read index i walks 0..DEPTH_F*DEPTH_F-1 in order; row r=i/DEPTH_F, kept as separate row/col counters (no divider).
  - out_valid=1 starting the cycle after entry to SEND, so the first packet appears 1 cycle after the final write accept.
  - Packet fields: dest=DEST_BASE+r (truncated to WIDTH_dest), datatype=TYPE_FILTER, addr=i zero-extended, data=mem[i]. Data is the value of the last write, including overwrites.
  - out_packet and out_valid hold stable while out_ready=0; no packet is dropped or repeated.
  - With out_ready held high: one packet per cycle, 25 packets in 25 consecutive cycles.
  - On acceptance of i = DEPTH_F*DEPTH_F-1: next state DONE, out_valid deasserts next cycle.
- DONE state (1 cycle):
  - done=1; bitmap and count cleared.
  - Next state LOAD, with in_ready=1 in the cycle after done.
  - Memory contents are retained but will be overwritten by the next frame.
- Simultaneous events: in_valid during SEND/DONE is ignored (in_ready=0); upstream must hold its word.
- Registered outputs only; no combinational path from in_valid or out_ready to any output.
- Implementation: memory is a register array, read index registered, packet formed from registered data.

Test Plan:
- Load addr 0..24 with data=addr+1, out_ready=1 -> 25 packets, one per cycle starting 1 cycle after the 25th accept; packet i has dest=i/5, datatype=0, addr=i, data=i+1; done pulses once; in_ready returns 1 the cycle after done.
- Load addresses in reverse order 24..0 -> identical packet stream to the first scenario (ordering is by address, not by arrival).
- Write addr 7 = 0x11, then addr 7 = 0x22, then the remaining 24 addresses -> SEND starts only after all 25 distinct addresses are written; packet for addr 7 has data=0x22.
- Write addr 30 mid-load -> err_addr=1 and stays 1 through the broadcast; count unaffected, broadcast still needs all 25 valid addresses.
- During SEND, toggle out_ready as 1,0,0,1,0,1... -> out_packet stable across every stall; exactly 25 accepted packets, with addresses contiguous 0..24.
- Assert rst while packet 12 is pending -> next cycle out_valid=0, in_ready=1 (after the reset cycle), err_addr=0; a fresh full load produces a complete 25-packet broadcast.
